slave_port: RTL and testbench
=============================

# slave_port

Slave-side endpoint of the serial bus: the responder that terminates the bit-serial address, burst-count and data lines driven by the master port. It deserialises the header and write data into parallel memory-side writes, and serialises read data back to the master with a valid/ready handshake. It sits between the bus multiplexer's per-slave outputs and a slave core (register file or BRAM) with 1-cycle read latency.

## Interface
- ADDRESS_LEN, 12, address width; serial header length in cycles; must be ≥ BURST_SIZE
- WORD_SIZE, 8, data word width; bits per serial word
- BURST_SIZE, 12, burst-count field width
- clk  in  1  system clock; everything on rising edge
- reset  in  1  asynchronous, active-high; returns block to IDLE
- rx_address  in  1  serial address, LSB first
- rx_burst_num  in  1  serial burst count, LSB first
- rx_data  in  1  serial write data, LSB first
- write_en  in  1  master requests write transaction
- read_en  in  1  master requests read transaction
- master_valid  in  1  master's serial bit on rx_* is valid this cycle
- master_ready  in  1  master accepts tx_data bit this cycle
- tx_data  out  1  serial read data, LSB first
- slave_valid  out  1  tx_data holds a valid bit
- slave_ready  out  1  slave samples rx_* this cycle
- mem_address  out  ADDRESS_LEN  core address for current word
- mem_wdata  out  WORD_SIZE  deserialised write word
- mem_write  out  1  1-cycle write strobe
- mem_read  out  1  1-cycle read strobe
- mem_rdata  in  WORD_SIZE  core read data, valid the cycle after mem_read
- trans_done  out  1  1-cycle pulse at transaction end

## Operation
- States: IDLE, HEADER, WDATA, RREQ, RWAIT, RSEND.
- A bit is "taken" on a cycle with master_valid && slave_ready.
- IDLE: slave_ready=1. On master_valid && (write_en ^ read_en), latch the direction and take header bit 0 of rx_address/rx_burst_num, then go to HEADER. write_en && read_en together: ignored, stay IDLE.
- HEADER: take ADDRESS_LEN address bits total. Burst bits are sampled on the first BURST_SIZE taken cycles; rx_burst_num is ignored afterwards. Last bit goes to WDATA (write) or RREQ (read).
- Burst count N = burst_num. N=0 is treated as 1. Word index k runs 0..N-1. mem_address = base + k, modulo 2^ADDRESS_LEN (wraps).
- WDATA: take WORD_SIZE bits into the shift register. The cycle after the last bit, mem_write=1 with mem_address/mem_wdata stable. The next word's bit 0 may be taken in that same cycle. The final word raises trans_done with its mem_write and returns to IDLE.
- RREQ: mem_read=1 for one cycle; slave_ready=0.
- RWAIT: capture mem_rdata into the shift register; slave_ready=0.
- RSEND: slave_valid=1, tx_data = shift register LSB. The register shifts on slave_valid && master_ready. After WORD_SIZE accepted bits: go to RREQ for word k+1, or, on the last word, pulse trans_done and return to IDLE. slave_ready=0 in RSEND.
- Abort: if write_en and read_en are both 0 in any non-IDLE state, go to IDLE next cycle. No mem strobe, no trans_done; the partial word is discarded.
- Reset mid-transaction: immediate IDLE; counters and shift registers cleared.

## Timing
- Reset values: tx_data=0, slave_valid=0, slave_ready=1 (IDLE), mem_address=0, mem_wdata=0, mem_write=0, mem_read=0, trans_done=0.
- Gaps (master_valid=0 or master_ready=0) stall the bit counters indefinitely; bits are never lost or duplicated.
- Write: last data bit taken at T → mem_write at T+1.
- Read: last header bit at T → mem_read at T+1, capture at T+2, slave_valid with bit 0 at T+3.
- Between read words: last bit accepted at T → mem_read at T+1 → next bit 0 at T+3.
- Read end: last bit of last word accepted at T → trans_done at T+1, in IDLE.
- All outputs are registered except slave_ready/slave_valid, which decode directly from state.

## Structure
- serial_bus_pkg: slave_state_t enum, parameter defaults, LSB-first convention constant.
- Counter widths: bit counter $clog2(ADDRESS_LEN+1) (covers WORD_SIZE when smaller; size to the max of the two); word counter BURST_SIZE bits.
- One sub-module: slave_out_port, the read serialiser (load, shift, slave_valid/master_ready handshake).

## Test plan
- Write, base 0x005, burst 2, data 0xA5, 0x3C, continuous valid → mem_write (0x005,0xA5) then (0x006,0x3C); trans_done with the second strobe.
- Read, base 0xFFF, burst 2, core returns addr[7:0] → mem_read at 0xFFF then 0x000 (wrap); tx_data carries 0xFF then 0x00, LSB first; trans_done once.
- Read, burst 1, master_ready toggling 1/0 → every bit held until accepted; 8 accepts total; slave_valid drops after the last one.
- write_en dropped after 4 data bits → IDLE next cycle; no mem_write, no trans_done; a following write works normally.
- write_en && read_en asserted together in IDLE → stays IDLE; slave_ready=1; no strobes.
- Reset asserted mid-RSEND → all outputs at reset values within the same cycle (asynchronous); next read completes correctly.

Source files
------------

// File: rtl/serial_bus_pkg.sv
// Shared types and defaults for the serial bus slave endpoint.
package serial_bus_pkg;

    localparam int unsigned ADDRESS_LEN_DEFAULT = 12;
    localparam int unsigned WORD_SIZE_DEFAULT   = 8;
    localparam int unsigned BURST_SIZE_DEFAULT  = 12;

    // Every serial field travels LSB first; shift registers fill from the MSB end.
    localparam bit SERIAL_LSB_FIRST = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        WDATA,
        RREQ,
        RWAIT,
        RSEND
    } slave_state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/slave_port_if.sv
// Bit-serial master/slave bus between a master port and a slave endpoint.
interface slave_port_if;

    logic rx_address;
    logic rx_burst_num;
    logic rx_data;
    logic write_en;
    logic read_en;
    logic master_valid;
    logic master_ready;
    logic tx_data;
    logic slave_valid;
    logic slave_ready;

    modport master (
        output rx_address, rx_burst_num, rx_data,
        output write_en, read_en, master_valid, master_ready,
        input  tx_data, slave_valid, slave_ready
    );

    modport slave (
        input  rx_address, rx_burst_num, rx_data,
        input  write_en, read_en, master_valid, master_ready,
        output tx_data, slave_valid, slave_ready
    );

endinterface

// File: rtl/slave_out_port.sv
// Read serialiser: loads a core word, shifts it out LSB first under valid/ready.
module slave_out_port #(
    parameter int unsigned WORD_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_load,
    input  logic [WORD_SIZE-1:0] i_load_data,
    input  logic                 i_active,
    input  logic                 i_master_ready,
    input  logic                 i_clear,
    output logic                 o_tx_data,
    output logic                 o_slave_valid,
    output logic                 o_word_done
);

    localparam int unsigned CNT_W = $clog2(WORD_SIZE + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORD_SIZE - 1);

    logic [WORD_SIZE-1:0] r_shift;
    logic [CNT_W-1:0]     r_cnt;
    logic                 w_accept;

    assign w_accept      = i_active && i_master_ready;
    assign o_tx_data     = r_shift[0];
    assign o_slave_valid = i_active;
    assign o_word_done   = w_accept && (r_cnt == WORD_LAST);

    // Load, then shift one bit per accepted handshake; abort discards the word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_shift <= i_load_data;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_shift <= r_shift >> 1;
            r_cnt   <= (r_cnt == WORD_LAST) ? '0 : r_cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/slave_port.sv
// Serial bus slave endpoint: header/write deserialiser, burst sequencer, read path.
module slave_port
    import serial_bus_pkg::*;
#(
    parameter int unsigned ADDRESS_LEN = ADDRESS_LEN_DEFAULT,
    parameter int unsigned WORD_SIZE   = WORD_SIZE_DEFAULT,
    parameter int unsigned BURST_SIZE  = BURST_SIZE_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    slave_port_if.slave            bus,
    output logic [ADDRESS_LEN-1:0] mem_address,
    output logic [WORD_SIZE-1:0]   mem_wdata,
    output logic                   mem_write,
    output logic                   mem_read,
    input  logic [WORD_SIZE-1:0]   mem_rdata,
    output logic                   trans_done
);

    localparam int unsigned CNT_W = $clog2(max_u(ADDRESS_LEN, WORD_SIZE) + 1);
    localparam logic [CNT_W-1:0]       CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]       HDR_LAST   = CNT_W'(ADDRESS_LEN - 1);
    localparam logic [CNT_W-1:0]       WORD_LAST  = CNT_W'(WORD_SIZE - 1);
    localparam logic [CNT_W-1:0]       BURST_BITS = CNT_W'(BURST_SIZE);
    localparam logic [BURST_SIZE-1:0]  BURST_ONE  = BURST_SIZE'(1);
    localparam logic [ADDRESS_LEN-1:0] ADDR_ONE   = ADDRESS_LEN'(1);

    slave_state_t           r_state;
    logic                   r_is_read;
    logic [CNT_W-1:0]       r_bit_cnt;
    // Address/data registers hold only the bits already taken; the bit on the
    // wire this cycle completes the field in the w_*_next wires.
    logic [ADDRESS_LEN-2:0] r_addr_sr;
    logic [WORD_SIZE-2:0]   r_wdata_sr;
    logic [BURST_SIZE-1:0]  r_burst_sr;
    logic [BURST_SIZE-1:0]  r_last_word;
    logic [BURST_SIZE-1:0]  r_word_cnt;
    logic [ADDRESS_LEN-1:0] r_mem_address;
    logic [WORD_SIZE-1:0]   r_mem_wdata;
    logic                   r_mem_write;
    logic                   r_mem_read;
    logic                   r_trans_done;

    logic                   w_slave_ready;
    logic                   w_take;
    logic                   w_abort;
    logic                   w_load;
    logic                   w_rsend;
    logic                   w_word_done;
    logic                   w_tx_data;
    logic                   w_slave_valid;
    logic                   w_last_word;
    logic [ADDRESS_LEN-1:0] w_addr_next;
    logic [WORD_SIZE-1:0]   w_wdata_next;
    logic [BURST_SIZE-1:0]  w_burst_next;

    // Decode handshake qualifiers and the next contents of the input shifters.
    always_comb begin
        w_slave_ready = (r_state == IDLE) || (r_state == HEADER) || (r_state == WDATA);
        w_take        = bus.master_valid && w_slave_ready;
        w_abort       = (r_state != IDLE) && !bus.write_en && !bus.read_en;
        w_rsend       = (r_state == RSEND);
        w_load        = (r_state == RWAIT) && !w_abort;
        w_last_word   = (r_word_cnt == r_last_word);
        w_addr_next   = {bus.rx_address, r_addr_sr};
        w_wdata_next  = {bus.rx_data, r_wdata_sr};
        w_burst_next  = (r_bit_cnt < BURST_BITS) ? {bus.rx_burst_num, r_burst_sr[BURST_SIZE-1:1]}
                                                 : r_burst_sr;
    end

    slave_out_port #(
        .WORD_SIZE(WORD_SIZE)
    ) u_out (
        .clk           (clk),
        .reset         (reset),
        .i_load        (w_load),
        .i_load_data   (mem_rdata),
        .i_active      (w_rsend),
        .i_master_ready(bus.master_ready),
        .i_clear       (w_abort),
        .o_tx_data     (w_tx_data),
        .o_slave_valid (w_slave_valid),
        .o_word_done   (w_word_done)
    );

    assign bus.slave_ready = w_slave_ready;
    assign bus.slave_valid = w_slave_valid;
    assign bus.tx_data     = w_tx_data;
    assign mem_address     = r_mem_address;
    assign mem_wdata       = r_mem_wdata;
    assign mem_write       = r_mem_write;
    assign mem_read        = r_mem_read;
    assign trans_done      = r_trans_done;

    // Transaction FSM with registered memory strobes and completion pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_is_read     <= 1'b0;
            r_bit_cnt     <= '0;
            r_addr_sr     <= '0;
            r_wdata_sr    <= '0;
            r_burst_sr    <= '0;
            r_last_word   <= '0;
            r_word_cnt    <= '0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
            r_mem_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_trans_done  <= 1'b0;
        end else begin
            r_mem_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_trans_done <= 1'b0;
            // Advance past a written word once its strobe has been presented.
            if (r_mem_write && (r_state == WDATA)) begin
                r_mem_address <= r_mem_address + ADDR_ONE;
            end
            if (w_abort) begin
                r_state   <= IDLE;
                r_bit_cnt <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_bit_cnt <= '0;
                        if (bus.master_valid && (bus.write_en ^ bus.read_en)) begin
                            r_is_read  <= bus.read_en;
                            r_addr_sr  <= w_addr_next[ADDRESS_LEN-1:1];
                            r_burst_sr <= w_burst_next;
                            r_bit_cnt  <= CNT_ONE;
                            r_state    <= HEADER;
                        end
                    end
                    HEADER: begin
                        if (w_take) begin
                            r_addr_sr  <= w_addr_next[ADDRESS_LEN-1:1];
                            r_burst_sr <= w_burst_next;
                            if (r_bit_cnt == HDR_LAST) begin
                                r_bit_cnt     <= '0;
                                r_word_cnt    <= '0;
                                r_mem_address <= w_addr_next;
                                r_last_word   <= (w_burst_next == '0) ? '0 : w_burst_next - BURST_ONE;
                                if (r_is_read) begin
                                    r_mem_read <= 1'b1;
                                    r_state    <= RREQ;
                                end else begin
                                    r_state    <= WDATA;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CNT_ONE;
                            end
                        end
                    end
                    WDATA: begin
                        if (w_take) begin
                            r_wdata_sr <= w_wdata_next[WORD_SIZE-1:1];
                            if (r_bit_cnt == WORD_LAST) begin
                                r_bit_cnt   <= '0;
                                r_mem_wdata <= w_wdata_next;
                                r_mem_write <= 1'b1;
                                if (w_last_word) begin
                                    r_trans_done <= 1'b1;
                                    r_state      <= IDLE;
                                end else begin
                                    r_word_cnt <= r_word_cnt + BURST_ONE;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CNT_ONE;
                            end
                        end
                    end
                    RREQ: begin
                        r_state <= RWAIT;
                    end
                    RWAIT: begin
                        r_state <= RSEND;
                    end
                    RSEND: begin
                        if (w_word_done) begin
                            if (w_last_word) begin
                                r_trans_done <= 1'b1;
                                r_state      <= IDLE;
                            end else begin
                                r_word_cnt    <= r_word_cnt + BURST_ONE;
                                r_mem_address <= r_mem_address + ADDR_ONE;
                                r_mem_read    <= 1'b1;
                                r_state       <= RREQ;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_slave_port.sv
`timescale 1ns/1ps
module tb_slave_port;

    localparam int AL = 12;
    localparam int WS = 8;
    localparam int BS = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AL-1:0] mem_address;
    logic [WS-1:0] mem_wdata;
    logic [WS-1:0] mem_rdata = '0;
    logic          mem_write;
    logic          mem_read;
    logic          trans_done;

    slave_port_if bus();

    slave_port #(
        .ADDRESS_LEN(AL),
        .WORD_SIZE  (WS),
        .BURST_SIZE (BS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .mem_address(mem_address),
        .mem_wdata  (mem_wdata),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .mem_rdata  (mem_rdata),
        .trans_done (trans_done)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Core model: 1-cycle read latency, data is a keyed function of the address.
    logic [7:0] core_key = 8'h00;
    always @(posedge clk) if (mem_read) mem_rdata <= mem_address[7:0] ^ core_key;

    // Passive monitor of memory-side and serial read-side activity.
    logic [AL-1:0] mw_addr[$];
    logic [WS-1:0] mw_data[$];
    int unsigned   mw_cyc[$];
    logic [AL-1:0] mr_addr[$];
    int unsigned   mr_cyc[$];
    bit            tx_bits[$];
    int            td_n;
    int unsigned   td_cyc;

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_write) begin
                mw_addr.push_back(mem_address);
                mw_data.push_back(mem_wdata);
                mw_cyc.push_back(cyc);
            end
            if (mem_read) begin
                mr_addr.push_back(mem_address);
                mr_cyc.push_back(cyc);
            end
            if (trans_done) begin
                td_n++;
                td_cyc = cyc;
            end
            if (bus.slave_valid && bus.master_ready) tx_bits.push_back(bus.tx_data);
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  wq[$];
    int unsigned t_hdr, t_last_take, t_first_valid;
    bit          sv_after;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        mw_addr.delete(); mw_data.delete(); mw_cyc.delete();
        mr_addr.delete(); mr_cyc.delete(); tx_bits.delete();
        td_n = 0; td_cyc = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Drives one transaction bit by bit; stop_bits >= 0 stops after that many data bits.
    task automatic run_txn(input bit is_read, input logic [AL-1:0] base, input logic [BS-1:0] burst,
                           input int gap_pct, input bit toggle_ready, input int stop_bits);
        int idx, nw, total, budget;
        bit mv, took, mr, acc;
        nw = (burst == '0) ? 1 : int'(burst);
        total = nw * WS;
        clear_mon();
        t_first_valid = 0;
        bus.write_en = !is_read;
        bus.read_en  = is_read;
        idx = 0;
        budget = 3000;
        while (idx < AL && budget > 0) begin
            mv = ($urandom_range(0, 99) >= gap_pct);
            bus.master_valid = mv;
            bus.rx_address   = mv ? base[idx] : 1'($urandom);
            bus.rx_burst_num = mv ? burst[idx] : 1'($urandom);
            bus.rx_data      = 1'($urandom);
            took = mv && bus.slave_ready;
            if (took && idx == AL - 1) t_hdr = cyc;
            @(posedge clk); #1;
            if (took) idx++;
            budget--;
        end
        idx = 0;
        if (!is_read) begin
            while (idx < total && budget > 0 && !(stop_bits >= 0 && idx == stop_bits)) begin
                mv = ($urandom_range(0, 99) >= gap_pct);
                bus.master_valid = mv;
                bus.rx_data = mv ? wq[idx / WS][idx % WS] : 1'($urandom);
                took = mv && bus.slave_ready;
                if (took) t_last_take = cyc;
                @(posedge clk); #1;
                if (took) idx++;
                budget--;
            end
        end else begin
            bus.master_valid = 1'b0;
            while (idx < total && budget > 0 && !(stop_bits >= 0 && idx == stop_bits)) begin
                mr = toggle_ready ? cyc[0] : ($urandom_range(0, 99) >= gap_pct);
                bus.master_ready = mr;
                if (bus.slave_valid && t_first_valid == 0) t_first_valid = cyc;
                acc = mr && bus.slave_valid;
                if (acc) t_last_take = cyc;
                @(posedge clk); #1;
                if (acc) idx++;
                budget--;
            end
            sv_after = bus.slave_valid;
        end
        chk("cycle_budget", 32'(budget > 0), 32'd1);
        if (stop_bits < 0 || !is_read) begin
            bus.master_valid = 1'b0;
            bus.master_ready = 1'b0;
            bus.write_en     = 1'b0;
            bus.read_en      = 1'b0;
            idle(4);
        end
    endtask

    task automatic check_write(input string tag, input logic [AL-1:0] base, input logic [BS-1:0] burst);
        int nw;
        nw = (burst == '0) ? 1 : int'(burst);
        chk({tag, ".n_write"}, 32'(mw_addr.size()), 32'(nw));
        chk({tag, ".n_read"}, 32'(mr_addr.size()), 32'd0);
        for (int k = 0; k < nw && k < mw_addr.size(); k++) begin
            chk({tag, ".addr"}, 32'(mw_addr[k]), 32'(AL'(base + AL'(k))));
            chk({tag, ".data"}, 32'(mw_data[k]), 32'(wq[k]));
        end
        chk({tag, ".done_n"}, 32'(td_n), 32'd1);
        if (mw_cyc.size() > 0) begin
            chk({tag, ".wr_lat"}, mw_cyc[mw_cyc.size()-1], t_last_take + 1);
            chk({tag, ".done_cyc"}, td_cyc, mw_cyc[mw_cyc.size()-1]);
        end
    endtask

    task automatic check_read(input string tag, input logic [AL-1:0] base, input logic [BS-1:0] burst);
        int nw;
        logic [7:0] got, exp_b;
        logic [AL-1:0] ea;
        nw = (burst == '0) ? 1 : int'(burst);
        chk({tag, ".n_read"}, 32'(mr_addr.size()), 32'(nw));
        chk({tag, ".n_write"}, 32'(mw_addr.size()), 32'd0);
        chk({tag, ".n_bits"}, 32'(tx_bits.size()), 32'(nw * WS));
        for (int k = 0; k < nw; k++) begin
            ea = AL'(base + AL'(k));
            if (k < mr_addr.size()) chk({tag, ".raddr"}, 32'(mr_addr[k]), 32'(ea));
            exp_b = ea[7:0] ^ core_key;
            got = '0;
            for (int b = 0; b < WS; b++) if (k * WS + b < tx_bits.size()) got[b] = tx_bits[k * WS + b];
            chk({tag, ".rbyte"}, 32'(got), 32'(exp_b));
        end
        if (mr_cyc.size() > 0) chk({tag, ".rd_lat"}, mr_cyc[0], t_hdr + 1);
        chk({tag, ".valid_lat"}, t_first_valid, t_hdr + 3);
        chk({tag, ".done_n"}, 32'(td_n), 32'd1);
        chk({tag, ".done_cyc"}, td_cyc, t_last_take + 1);
        chk({tag, ".valid_end"}, 32'(sv_after), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".tx_data"}, 32'(bus.tx_data), 32'd0);
        chk({tag, ".slave_valid"}, 32'(bus.slave_valid), 32'd0);
        chk({tag, ".slave_ready"}, 32'(bus.slave_ready), 32'd1);
        chk({tag, ".mem_address"}, 32'(mem_address), 32'd0);
        chk({tag, ".mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, ".mem_write"}, 32'(mem_write), 32'd0);
        chk({tag, ".mem_read"}, 32'(mem_read), 32'd0);
        chk({tag, ".trans_done"}, 32'(trans_done), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sr_low;
        bit rd;
        logic [AL-1:0] b;
        logic [BS-1:0] n;
        int g;

        bus.rx_address = 1'b0; bus.rx_burst_num = 1'b0; bus.rx_data = 1'b0;
        bus.write_en = 1'b0; bus.read_en = 1'b0;
        bus.master_valid = 1'b0; bus.master_ready = 1'b0;
        clear_mon();
        idle(3);
        check_reset_outputs("reset");
        reset = 1'b0;
        idle(2);

        // Two-word write with continuous valid.
        wq.delete(); wq.push_back(8'hA5); wq.push_back(8'h3C);
        run_txn(1'b0, 12'h005, 12'd2, 0, 1'b0, -1);
        check_write("wr_basic", 12'h005, 12'd2);

        // Two-word read wrapping from 0xFFF to 0x000.
        core_key = 8'h00;
        run_txn(1'b1, 12'hFFF, 12'd2, 0, 1'b0, -1);
        check_read("rd_wrap", 12'hFFF, 12'd2);

        // Single-word read with master_ready alternating.
        core_key = 8'h5A;
        run_txn(1'b1, 12'h0C3, 12'd1, 0, 1'b1, -1);
        check_read("rd_toggle", 12'h0C3, 12'd1);

        // Burst count of zero behaves as one word.
        wq.delete(); wq.push_back(8'h81);
        run_txn(1'b0, 12'h7FE, 12'd0, 20, 1'b0, -1);
        check_write("wr_burst0", 12'h7FE, 12'd0);

        // Write aborted after four data bits, then a normal write.
        wq.delete(); wq.push_back(8'hFF);
        run_txn(1'b0, 12'h100, 12'd1, 0, 1'b0, 4);
        chk("abort.n_write", 32'(mw_addr.size()), 32'd0);
        chk("abort.done_n", 32'(td_n), 32'd0);
        wq.delete(); wq.push_back(8'h69); wq.push_back(8'h12);
        run_txn(1'b0, 12'h200, 12'd2, 30, 1'b0, -1);
        check_write("wr_after_abort", 12'h200, 12'd2);

        // Both enables together in IDLE are ignored.
        clear_mon();
        sr_low = 0;
        bus.write_en = 1'b1; bus.read_en = 1'b1; bus.master_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.rx_address = 1'($urandom); bus.rx_burst_num = 1'($urandom); bus.rx_data = 1'($urandom);
            if (bus.slave_ready !== 1'b1) sr_low++;
            @(posedge clk); #1;
        end
        bus.write_en = 1'b0; bus.read_en = 1'b0; bus.master_valid = 1'b0;
        idle(2);
        chk("both_en.ready_low", 32'(sr_low), 32'd0);
        chk("both_en.n_write", 32'(mw_addr.size()), 32'd0);
        chk("both_en.n_read", 32'(mr_addr.size()), 32'd0);
        chk("both_en.done_n", 32'(td_n), 32'd0);

        // Randomized transactions with gaps.
        for (int t = 0; t < 12; t++) begin
            rd = 1'($urandom);
            b  = AL'($urandom);
            n  = BS'($urandom_range(0, 3));
            g  = $urandom_range(0, 50);
            core_key = 8'($urandom);
            if (!rd) begin
                wq.delete();
                for (int k = 0; k < ((n == '0) ? 1 : int'(n)); k++) wq.push_back(8'($urandom));
                run_txn(1'b0, b, n, g, 1'b0, -1);
                check_write("rand_wr", b, n);
            end else begin
                run_txn(1'b1, b, n, g, 1'b0, -1);
                check_read("rand_rd", b, n);
            end
        end

        // Asynchronous reset in the middle of a read word.
        core_key = 8'h33;
        run_txn(1'b1, 12'h123, 12'd2, 0, 1'b0, 5);
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        bus.master_ready = 1'b0; bus.read_en = 1'b0; bus.master_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        idle(2);
        run_txn(1'b1, 12'h456, 12'd2, 10, 1'b0, -1);
        check_read("rd_after_reset", 12'h456, 12'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
